// File: rtl/image_gray_capture.sv
// image_gray_capture
//
// Camera front-end on the pixel clock. Discards the first FRAME_SKIP complete
// sensor frames after reset, pairs RGB565 bytes into pixels and converts each
// pixel to 8-bit grayscale through a three-register pipeline. Sync outputs are
// delayed by the same three registers so they stay aligned with the pixels.
//
// Ports:
//   clk_pixel   in   pixel clock, all logic on its rising edge
//   rst_n       in   asynchronous active-low reset
//   cam_vsync   in   sensor frame-active
//   cam_href    in   sensor line-active
//   cam_data    in   sensor byte (RGB565 high byte first)
//   frame_ready out  FRAME_SKIP frames have been discarded (sticky)
//   vsync       out  delayed, gated cam_vsync
//   hsync       out  delayed, gated cam_href
//   valid       out  one-cycle strobe, pixel_data holds a new pixel
//   pixel_data  out  grayscale pixel, holds between strobes
module image_gray_capture #(
  parameter int FRAME_SKIP = 10
) (
  input  logic       clk_pixel,
  input  logic       rst_n,
  input  logic       cam_vsync,
  input  logic       cam_href,
  input  logic [7:0] cam_data,
  output logic       frame_ready,
  output logic       vsync,
  output logic       hsync,
  output logic       valid,
  output logic [7:0] pixel_data
);

  localparam int SKIP_W = (FRAME_SKIP < 1) ? 1 : $clog2(FRAME_SKIP + 1);
  localparam logic [SKIP_W-1:0] SKIP_MAX = SKIP_W'(FRAME_SKIP);

  function automatic logic [7:0] expand5(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction

  function automatic logic [7:0] expand6(input logic [5:0] c);
    return {c, c[5:4]};
  endfunction

  // The weights sum to 256, so the top byte of the sum is the gray level.
  function automatic logic [7:0] gray_trunc(input logic [15:0] s);
    return s[15:8];
  endfunction

  logic              vs_d;
  logic              vs_primed;
  logic              in_frame;
  logic              frame_en;
  logic              byte_phase;
  logic [SKIP_W-1:0] skip_cnt;
  logic [7:0]        hi_byte;

  logic              vs_rise;
  logic              vs_fall;
  logic              frame_open;
  logic              byte_acc;
  logic              pair_done;

  // vs_primed suppresses edge detection on the first sample after reset, so a
  // frame already in progress at release is neither opened nor counted.
  assign vs_rise     = vs_primed & cam_vsync & ~vs_d;
  assign vs_fall     = vs_primed & ~cam_vsync & vs_d;
  assign frame_ready = (skip_cnt == SKIP_MAX);
  // Gate with the next-state value so the opening vsync cycle is not lost.
  assign frame_open  = frame_en | (vs_rise & frame_ready);
  assign byte_acc    = cam_vsync & cam_href;
  assign pair_done   = byte_acc & byte_phase;

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      vs_d       <= 1'b0;
      vs_primed  <= 1'b0;
      in_frame   <= 1'b0;
      frame_en   <= 1'b0;
      byte_phase <= 1'b0;
      skip_cnt   <= '0;
      hi_byte    <= '0;
    end else begin
      vs_d      <= cam_vsync;
      vs_primed <= 1'b1;
      if (vs_rise) begin
        in_frame <= 1'b1;
      end else if (vs_fall) begin
        in_frame <= 1'b0;
      end
      // Only frames whose start was seen count as complete skipped frames.
      if (vs_fall && in_frame && (skip_cnt != SKIP_MAX)) begin
        skip_cnt <= skip_cnt + SKIP_W'(1);
      end
      frame_en <= frame_open;
      if (!cam_href) begin
        byte_phase <= 1'b0;
      end else if (byte_acc) begin
        byte_phase <= ~byte_phase;
      end
      if (byte_acc && !byte_phase) begin
        hi_byte <= cam_data;
      end
    end
  end

  // Stage p0: assembled pixel and gated sync
  logic        stb_p0;
  logic        href_p0;
  logic        vs_p0;
  logic [15:0] rgb_p0;

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      stb_p0  <= 1'b0;
      href_p0 <= 1'b0;
      vs_p0   <= 1'b0;
      rgb_p0  <= '0;
    end else begin
      stb_p0  <= pair_done & frame_open;
      href_p0 <= cam_href & cam_vsync & frame_open;
      vs_p0   <= cam_vsync & frame_open;
      if (pair_done) begin
        rgb_p0 <= {hi_byte, cam_data};
      end
    end
  end

  // Stage p1: weighted channels
  logic        stb_p1;
  logic        href_p1;
  logic        vs_p1;
  logic [15:0] r_mul_p1;
  logic [15:0] g_mul_p1;
  logic [15:0] b_mul_p1;
  logic [15:0] sum_p1;

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      stb_p1   <= 1'b0;
      href_p1  <= 1'b0;
      vs_p1    <= 1'b0;
      r_mul_p1 <= '0;
      g_mul_p1 <= '0;
      b_mul_p1 <= '0;
    end else begin
      stb_p1   <= stb_p0;
      href_p1  <= href_p0;
      vs_p1    <= vs_p0;
      r_mul_p1 <= 16'(expand5(rgb_p0[15:11])) * 16'd77;
      g_mul_p1 <= 16'(expand6(rgb_p0[10:5]))  * 16'd150;
      b_mul_p1 <= 16'(expand5(rgb_p0[4:0]))   * 16'd29;
    end
  end

  // Maximum 19635 + 38250 + 7395 = 65280, so 16 bits cannot overflow.
  assign sum_p1 = r_mul_p1 + g_mul_p1 + b_mul_p1;

  // Stage p2: output registers
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      valid      <= 1'b0;
      hsync      <= 1'b0;
      vsync      <= 1'b0;
      pixel_data <= '0;
    end else begin
      valid <= stb_p1;
      hsync <= href_p1;
      vsync <= vs_p1;
      if (stb_p1) begin
        pixel_data <= gray_trunc(sum_p1);
      end
    end
  end

endmodule

// File: tb/tb_image_gray_capture.sv
module tb_image_gray_capture;

  typedef logic [7:0] bq_t [$];

  logic       clk_pixel = 1'b0;
  logic       rst_n     = 1'b0;
  logic       cam_vsync = 1'b0;
  logic       cam_href  = 1'b0;
  logic [7:0] cam_data  = 8'h00;

  logic [2:0]      v_o;
  logic [2:0]      hs_o;
  logic [2:0]      vs_o;
  logic [2:0]      fr_o;
  logic [2:0][7:0] pd_o;

  always #5 clk_pixel = ~clk_pixel;

  image_gray_capture #(.FRAME_SKIP(2)) dut_fs2 (
    .clk_pixel(clk_pixel), .rst_n(rst_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .frame_ready(fr_o[0]), .vsync(vs_o[0]), .hsync(hs_o[0]),
    .valid(v_o[0]), .pixel_data(pd_o[0]));

  image_gray_capture #(.FRAME_SKIP(1)) dut_fs1 (
    .clk_pixel(clk_pixel), .rst_n(rst_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .frame_ready(fr_o[1]), .vsync(vs_o[1]), .hsync(hs_o[1]),
    .valid(v_o[1]), .pixel_data(pd_o[1]));

  image_gray_capture #(.FRAME_SKIP(0)) dut_fs0 (
    .clk_pixel(clk_pixel), .rst_n(rst_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .frame_ready(fr_o[2]), .vsync(vs_o[2]), .hsync(hs_o[2]),
    .valid(v_o[2]), .pixel_data(pd_o[2]));

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state, one slot per DUT
  int         fs_tab    [3];
  bit         m_primed  [3];
  bit         m_prev_vs [3];
  bit         m_inframe [3];
  bit         m_en      [3];
  int         m_frames  [3];
  int         m_nbytes  [3];
  logic [7:0] m_hi      [3];
  logic [7:0] m_pix     [3];
  // Expected events: index 0 newest, 2 is what the outputs show now.
  bit         q_v [3][3];
  bit         q_h [3][3];
  bit         q_s [3][3];
  logic [7:0] q_g [3][3];

  bit   log_v [4096];
  bit   log_h [4096];
  bit   cap_en = 1'b0;
  logic [7:0] cap_q [$];

  function automatic logic [7:0] gray_ref(input int pix);
    int r5, g6, b5, r8, g8, b8;
    r5 = (pix >> 11) & 31;
    g6 = (pix >> 5) & 63;
    b5 = pix & 31;
    r8 = r5 * 8 + r5 / 4;
    g8 = g6 * 4 + g6 / 16;
    b8 = b5 * 8 + b5 / 4;
    return 8'((77 * r8 + 150 * g8 + 29 * b8) / 256);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 3; i++) begin
      m_primed[i] = 0; m_prev_vs[i] = 0; m_inframe[i] = 0; m_en[i] = 0;
      m_frames[i] = 0; m_nbytes[i] = 0; m_hi[i] = 0; m_pix[i] = 0;
      for (int s = 0; s < 3; s++) begin
        q_v[i][s] = 0; q_h[i][s] = 0; q_s[i][s] = 0; q_g[i][s] = 0;
      end
    end
  endtask

  task automatic model_edge();
    bit rise, fall, ev_v;
    logic [7:0] ev_g;
    if (!rst_n) begin
      m_reset();
      return;
    end
    for (int i = 0; i < 3; i++) begin
      rise = m_primed[i] && cam_vsync && !m_prev_vs[i];
      fall = m_primed[i] && !cam_vsync && m_prev_vs[i];
      if (rise && m_frames[i] >= fs_tab[i]) m_en[i] = 1;
      ev_v = 0;
      ev_g = 0;
      if (cam_vsync && cam_href) begin
        if (m_nbytes[i] % 2 == 1) begin
          ev_v = 1;
          ev_g = gray_ref({16'd0, m_hi[i], cam_data});
        end else begin
          m_hi[i] = cam_data;
        end
        m_nbytes[i]++;
      end
      if (!cam_href) m_nbytes[i] = 0;
      if (fall && m_inframe[i]) m_frames[i]++;
      if (rise) m_inframe[i] = 1;
      if (fall) m_inframe[i] = 0;
      m_prev_vs[i] = cam_vsync;
      m_primed[i]  = 1;
      for (int s = 2; s > 0; s--) begin
        q_v[i][s] = q_v[i][s-1]; q_h[i][s] = q_h[i][s-1];
        q_s[i][s] = q_s[i][s-1]; q_g[i][s] = q_g[i][s-1];
      end
      q_v[i][0] = ev_v && m_en[i];
      q_h[i][0] = cam_href && cam_vsync && m_en[i];
      q_s[i][0] = cam_vsync && m_en[i];
      q_g[i][0] = ev_g;
      if (q_v[i][2]) m_pix[i] = q_g[i][2];
    end
  endtask

  task automatic check_all();
    bit fr_exp;
    for (int i = 0; i < 3; i++) begin
      fr_exp = (m_frames[i] >= fs_tab[i]);
      n_assert++;
      assert (v_o[i] === q_v[i][2]) else begin
        n_fail++; $error("FAIL valid[%0d] cyc %0d got %0b exp %0b", i, cyc, v_o[i], q_v[i][2]);
      end
      n_assert++;
      assert (hs_o[i] === q_h[i][2]) else begin
        n_fail++; $error("FAIL hsync[%0d] cyc %0d got %0b exp %0b", i, cyc, hs_o[i], q_h[i][2]);
      end
      n_assert++;
      assert (vs_o[i] === q_s[i][2]) else begin
        n_fail++; $error("FAIL vsync[%0d] cyc %0d got %0b exp %0b", i, cyc, vs_o[i], q_s[i][2]);
      end
      n_assert++;
      assert (pd_o[i] === m_pix[i]) else begin
        n_fail++; $error("FAIL pixel_data[%0d] cyc %0d got %0d exp %0d", i, cyc, pd_o[i], m_pix[i]);
      end
      n_assert++;
      assert (fr_o[i] === fr_exp) else begin
        n_fail++; $error("FAIL frame_ready[%0d] cyc %0d got %0b exp %0b", i, cyc, fr_o[i], fr_exp);
      end
    end
  endtask

  task automatic step(input bit vs, input bit hr, input logic [7:0] d);
    @(negedge clk_pixel);
    cam_vsync = vs;
    cam_href  = hr;
    cam_data  = d;
    @(posedge clk_pixel);
    model_edge();
    #1;
    cyc++;
    if (cyc < 4096) begin
      log_v[cyc] = v_o[0];
      log_h[cyc] = hs_o[0];
    end
    if (cap_en && v_o[0]) cap_q.push_back(pd_o[0]);
    check_all();
  endtask

  task automatic send_line(input bq_t q);
    for (int j = 0; j < q.size(); j++) step(1'b1, 1'b1, q[j]);
    repeat (3) step(1'b1, 1'b0, 8'($urandom_range(0, 255)));
  endtask

  task automatic rand_line(input int n);
    bq_t q;
    for (int j = 0; j < n; j++) q.push_back(8'($urandom_range(0, 255)));
    send_line(q);
  endtask

  task automatic vs_up();
    repeat (2) step(1'b1, 1'b0, 8'($urandom_range(0, 255)));
  endtask

  // Frame gap; href pulses here lie outside vsync and must be ignored.
  task automatic vs_down();
    repeat (4) step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic rand_frame(input int nlines, input int nbytes);
    vs_up();
    for (int l = 0; l < nlines; l++) rand_line(nbytes);
    vs_down();
  endtask

  task automatic check_cap(input string tag, input bq_t exp);
    n_assert++;
    assert (cap_q.size() == exp.size()) else begin
      n_fail++; $error("FAIL %s count got %0d exp %0d", tag, cap_q.size(), exp.size());
    end
    for (int j = 0; j < exp.size() && j < cap_q.size(); j++) begin
      n_assert++;
      assert (cap_q[j] === exp[j]) else begin
        n_fail++; $error("FAIL %s pixel %0d got %0d exp %0d", tag, j, cap_q[j], exp[j]);
      end
    end
  endtask

  initial begin
    bq_t q;
    bq_t e;
    int k;
    fs_tab[0] = 2; fs_tab[1] = 1; fs_tab[2] = 0;
    m_reset();

    // Reset held with the camera toggling
    rst_n = 1'b0;
    repeat (8) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    step(1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
    repeat (3) step(1'b0, 1'b0, 8'h00);

    // Frames A, B skipped by the FRAME_SKIP=2 instance, C output
    rand_frame(2, 8);
    n_assert++;
    assert (fr_o[0] === 1'b0) else begin
      n_fail++; $error("FAIL ready_after_1 got %0b exp 0", fr_o[0]);
    end
    rand_frame(2, 8);
    n_assert++;
    assert (fr_o[0] === 1'b1) else begin
      n_fail++; $error("FAIL ready_after_2 got %0b exp 1", fr_o[0]);
    end
    vs_up();
    for (int l = 0; l < 2; l++) begin
      cap_q.delete();
      cap_en = 1'b1;
      rand_line(8);
      cap_en = 1'b0;
      n_assert++;
      assert (cap_q.size() == 4) else begin
        n_fail++; $error("FAIL frame3_line%0d pulses got %0d exp 4", l, cap_q.size());
      end
    end
    vs_down();

    // Colour values
    vs_up();
    q = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F};
    e = '{8'd255, 8'd0, 8'd76, 8'd149, 8'd28};
    cap_q.delete();
    cap_en = 1'b1;
    send_line(q);
    cap_en = 1'b0;
    check_cap("colour", e);

    // Latency on a 4-byte line
    k = cyc + 1;
    q = '{8'h12, 8'h34, 8'hAB, 8'hCD};
    send_line(q);
    for (int t = 1; t <= 6; t++) begin
      n_assert++;
      assert (log_h[k+t] === ((t >= 2 && t <= 5) ? 1'b1 : 1'b0)) else begin
        n_fail++; $error("FAIL lat_hsync k+%0d got %0b", t, log_h[k+t]);
      end
      n_assert++;
      assert (log_v[k+t] === ((t == 3 || t == 5) ? 1'b1 : 1'b0)) else begin
        n_fail++; $error("FAIL lat_valid k+%0d got %0b", t, log_v[k+t]);
      end
    end
    vs_down();

    // Odd line followed by an even line
    vs_up();
    q = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h55};
    e = '{8'd76, 8'd149};
    cap_q.delete();
    cap_en = 1'b1;
    send_line(q);
    cap_en = 1'b0;
    check_cap("odd_line", e);
    q = '{8'h00, 8'h1F, 8'hFF, 8'hFF};
    e = '{8'd28, 8'd255};
    cap_q.delete();
    cap_en = 1'b1;
    send_line(q);
    cap_en = 1'b0;
    check_cap("after_odd", e);
    vs_down();

    // Reset mid-frame, released while cam_vsync is still high
    vs_up();
    for (int j = 0; j < 5; j++) step(1'b1, 1'b1, 8'($urandom_range(0, 255)));
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    check_all();
    for (int i = 0; i < 3; i++) begin
      n_assert++;
      assert ({v_o[i], hs_o[i], vs_o[i], pd_o[i]} === 11'd0) else begin
        n_fail++; $error("FAIL async_reset[%0d] got %0h exp 0", i, {v_o[i], hs_o[i], vs_o[i], pd_o[i]});
      end
    end
    repeat (3) step(1'b1, 1'b1, 8'($urandom_range(0, 255)));
    rst_n = 1'b1;
    step(1'b1, 1'b0, 8'h00);
    rand_line(8);
    rand_line(6);
    vs_down();

    // Next frame skipped (FRAME_SKIP=1), following frame output
    rand_frame(2, 8);
    rand_frame(2, 8);
    rand_frame(1, 7);
    rand_frame(2, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
